// File: rtl/spi_note_receiver_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_note_receiver_if
// Purpose : SPI pins from the host MCU plus the parallel note-event bus.
// Revision: 1.0
// ============================================================================
interface spi_note_receiver_if;
    logic        i_sclk;
    logic        i_mosi;
    logic        i_cs_n;
    logic        o_SPI_note_status;
    logic [7:0]  o_SPI_voice_index;
    logic [6:0]  o_SPI_velocity;
    logic [31:0] o_SPI_tuning_code;
    logic        o_SPI_ready_flag;
    logic        o_frame_error;

    modport slave (
        input  i_sclk, i_mosi, i_cs_n,
        output o_SPI_note_status, o_SPI_voice_index, o_SPI_velocity,
               o_SPI_tuning_code, o_SPI_ready_flag, o_frame_error
    );

    modport master (
        output i_sclk, i_mosi, i_cs_n,
        input  o_SPI_note_status, o_SPI_voice_index, o_SPI_velocity,
               o_SPI_tuning_code, o_SPI_ready_flag, o_frame_error
    );
endinterface
`default_nettype wire

// File: rtl/spi_note_receiver.sv
`default_nettype none
// ============================================================================
// Module  : spi_note_receiver
// Purpose : SPI mode-0 slave turning note-event frames into the note-event bus.
//           Define SPI_NOTE_RX_CHECKSUM_EN to append and verify an XOR byte.
// Revision: 1.0
// ============================================================================
module spi_note_receiver #(
    parameter int FRAME_BYTES = 7
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset,
    spi_note_receiver_if.slave bus
);

`ifdef SPI_NOTE_RX_CHECKSUM_EN
    localparam int CK_BITS = 8;
`else
    localparam int CK_BITS = 0;
`endif
    localparam int FRAME_BITS = FRAME_BYTES * 8 + CK_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            sclk_sync, mosi_sync, cs_sync;
    logic                  sclk_prev, sclk_rise, mosi_bit, cs_q;
    logic [1:0]            state, state_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  load_fields, flag_error;
    logic                  frame_ok, ck_ok;
    logic                  note_status, ready_flag, frame_error;
    logic [7:0]            voice_index;
    logic [6:0]            velocity;
    logic [31:0]           tuning_code;

    // Edge, data and chip-select all leave this block on the same cycle so
    // their relative ordering at the pins is preserved.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b11;
            sclk_prev <= 1'b0;
            sclk_rise <= 1'b0;
            mosi_bit  <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.i_sclk};
            mosi_sync <= {mosi_sync[0], bus.i_mosi};
            cs_sync   <= {cs_sync[0], bus.i_cs_n};
            sclk_prev <= sclk_sync[1];
            sclk_rise <= sclk_sync[1] & ~sclk_prev;
            mosi_bit  <= mosi_sync[1];
            cs_q      <= cs_sync[1];
        end
    end

    wire logic [7:0]  hdr_byte  = shreg[FRAME_BITS-1  -: 8];
    wire logic [7:0]  voice_byt = shreg[FRAME_BITS-9  -: 8];
    wire logic [7:0]  vel_byte  = shreg[FRAME_BITS-17 -: 8];
    wire logic [31:0] tune_word = shreg[CK_BITS +: 32];

`ifdef SPI_NOTE_RX_CHECKSUM_EN
    logic [7:0] ck_acc;
    // XOR over all bytes including the checksum byte is zero for a good frame.
    always_comb begin
        ck_acc = 8'h00;
        for (int i = 0; i < FRAME_BITS / 8; i++) begin
            ck_acc = ck_acc ^ shreg[i*8 +: 8];
        end
    end
    assign ck_ok = (ck_acc == 8'h00);
`else
    assign ck_ok = 1'b1;
`endif

    assign frame_ok = (hdr_byte[6:0] == 7'h5A) && !vel_byte[7] && ck_ok;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    // A final edge coinciding with cs_n rising still completes the frame.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!cs_q) state_next = S_SHIFT;
            S_SHIFT: begin
                if (sclk_rise && bit_cnt == LAST_BIT) state_next = S_CHECK;
                else if (cs_q)                        state_next = S_IDLE;
            end
            S_CHECK: state_next = S_DRAIN;
            S_DRAIN: if (cs_q) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_fields = 1'b0;
        flag_error  = 1'b0;
        case (state)
            S_SHIFT: flag_error = cs_q && !(sclk_rise && bit_cnt == LAST_BIT)
                                  && (sclk_rise || bit_cnt != '0);
            S_CHECK: begin
                load_fields = frame_ok;
                flag_error  = !frame_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (state == S_IDLE) begin
            bit_cnt <= '0;
        end else if (state == S_SHIFT && sclk_rise) begin
            shreg   <= {shreg[FRAME_BITS-2:0], mosi_bit};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ready_flag  <= 1'b0;
            frame_error <= 1'b0;
            note_status <= 1'b0;
            voice_index <= 8'h00;
            velocity    <= 7'h00;
            tuning_code <= 32'h0;
        end else begin
            ready_flag  <= load_fields;
            frame_error <= flag_error;
            if (load_fields) begin
                note_status <= hdr_byte[7];
                voice_index <= voice_byt;
                velocity    <= vel_byte[6:0];
                tuning_code <= tune_word;
            end
        end
    end

    assign bus.o_SPI_note_status = note_status;
    assign bus.o_SPI_voice_index = voice_index;
    assign bus.o_SPI_velocity    = velocity;
    assign bus.o_SPI_tuning_code = tuning_code;
    assign bus.o_SPI_ready_flag  = ready_flag;
    assign bus.o_frame_error     = frame_error;

endmodule
`default_nettype wire

// File: tb/tb_spi_note_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_note_receiver
// Purpose : Randomised self-checking bench for spi_note_receiver.
// Revision: 1.0
// ============================================================================
module tb_spi_note_receiver;

`ifdef SPI_NOTE_RX_CHECKSUM_EN
    localparam int NBYTES = 8;
`else
    localparam int NBYTES = 7;
`endif
    localparam int FRAME_BITS = NBYTES * 8;
    localparam int HALF       = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_note_receiver_if bus();

    spi_note_receiver #(.FRAME_BYTES(7)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ready = 0;
    int n_err = 0;
    int ready_cyc = 0;
    int err_cyc = 0;
    int last_rise_cyc = 0;
    logic [7:0] voice_q[$];

    logic [7:0] fb [8];
    logic        exp_status = 1'b0;
    logic [7:0]  exp_voice  = 8'h00;
    logic [6:0]  exp_vel    = 7'h00;
    logic [31:0] exp_tuning = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_SPI_ready_flag) begin
            n_ready++;
            ready_cyc = cyc;
            voice_q.push_back(bus.o_SPI_voice_index);
        end
        if (bus.o_frame_error) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fix_ck();
        fb[7] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4] ^ fb[5] ^ fb[6];
    endtask

    task automatic build_valid(input logic st, input logic [7:0] v, input logic [6:0] vel,
                               input logic [31:0] tune);
        fb[0] = {st, 7'h5A};
        fb[1] = v;
        fb[2] = {1'b0, vel};
        fb[3] = tune[31:24];
        fb[4] = tune[23:16];
        fb[5] = tune[15:8];
        fb[6] = tune[7:0];
        fix_ck();
    endtask

    task automatic build_random();
        build_valid(1'($urandom), 8'($urandom), 7'($urandom), $urandom);
    endtask

    // Frame outcome: 0 = nothing, 1 = ready strobe, 2 = error strobe.
    function automatic int model_kind(input int nbits);
`ifdef SPI_NOTE_RX_CHECKSUM_EN
        logic [7:0] x;
`endif
        if (nbits == 0) return 0;
        if (nbits < FRAME_BITS) return 2;
        if (fb[0][6:0] != 7'h5A || fb[2][7]) return 2;
`ifdef SPI_NOTE_RX_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ fb[i];
        if (x != 8'h00) return 2;
`endif
        return 1;
    endfunction

    task automatic model_load();
        exp_status = fb[0][7];
        exp_voice  = fb[1];
        exp_vel    = fb[2][6:0];
        exp_tuning = {fb[3], fb[4], fb[5], fb[6]};
    endtask

    task automatic check_fields(input string tag);
        check_val({tag, "_status"}, 64'(bus.o_SPI_note_status), 64'(exp_status));
        check_val({tag, "_voice"},  64'(bus.o_SPI_voice_index), 64'(exp_voice));
        check_val({tag, "_vel"},    64'(bus.o_SPI_velocity),    64'(exp_vel));
        check_val({tag, "_tune"},   64'(bus.o_SPI_tuning_code), 64'(exp_tuning));
    endtask

    task automatic send_frame(input int nbits, input int gap, input bit cs_on_edge, input int rst_bit);
        bus.i_cs_n = 1'b0;
        wait_neg(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst_n = 1'b0;
                exp_status = 1'b0;
                exp_voice  = 8'h00;
                exp_vel    = 7'h00;
                exp_tuning = 32'h0;
                wait_neg(2);
                check_fields("rst_mid");
                check_val("rst_mid_ready", 64'(bus.o_SPI_ready_flag), 64'd0);
                check_val("rst_mid_err",   64'(bus.o_frame_error),    64'd0);
                bus.i_cs_n = 1'b1;
                bus.i_sclk = 1'b0;
                bus.i_mosi = 1'b0;
                wait_neg(3);
                rst_n = 1'b1;
                wait_neg(8);
                return;
            end
            bus.i_mosi = (i < FRAME_BITS) ? fb[i/8][7 - (i % 8)] : 1'($urandom);
            wait_neg(HALF);
            bus.i_sclk = 1'b1;
            if (i == FRAME_BITS - 1) last_rise_cyc = cyc;
            if (cs_on_edge && i == nbits - 1) bus.i_cs_n = 1'b1;
            wait_neg(HALF);
            bus.i_sclk = 1'b0;
        end
        wait_neg(2);
        bus.i_cs_n = 1'b1;
        wait_neg(gap);
    endtask

    task automatic run_frame(input string tag, input int nbits, input bit cs_on_edge);
        int r0, e0, kind;
        r0   = n_ready;
        e0   = n_err;
        kind = model_kind(nbits);
        send_frame(nbits, 12, cs_on_edge, -1);
        if (kind == 1) model_load();
        check_val({tag, "_nready"}, 64'(n_ready - r0), 64'(kind == 1));
        check_val({tag, "_nerr"},   64'(n_err - e0),   64'(kind == 2));
        if (kind == 1)
            check_val({tag, "_rdy_lat"}, 64'(ready_cyc - last_rise_cyc), 64'd5);
        if (kind == 2 && nbits >= FRAME_BITS)
            check_val({tag, "_err_lat"}, 64'(err_cyc - last_rise_cyc), 64'd5);
        check_fields(tag);
    endtask

    initial begin
        int r0, e0, mode, nb, p;
        bus.i_sclk = 1'b0;
        bus.i_mosi = 1'b0;
        bus.i_cs_n = 1'b1;
        #1 rst_n = 1'b0;
        wait_neg(4);
        check_fields("reset");
        check_val("reset_ready", 64'(bus.o_SPI_ready_flag), 64'd0);
        check_val("reset_err",   64'(bus.o_frame_error),    64'd0);
        rst_n = 1'b1;
        wait_neg(4);

        build_valid(1'b1, 8'h05, 7'h64, 32'h01234567);
        run_frame("note_on", FRAME_BITS, 1'b0);

        build_random();
        run_frame("trunc20", 20, 1'b0);

        build_random();
        fb[0] = 8'h80;
        fix_ck();
        run_frame("bad_hdr", FRAME_BITS, 1'b0);

        build_random();
        fb[2] = 8'h80;
        fix_ck();
        run_frame("bad_vel", FRAME_BITS, 1'b0);

        build_random();
        run_frame("empty", 0, 1'b0);

        build_random();
        run_frame("cs_on_edge", FRAME_BITS, 1'b1);

        build_random();
        run_frame("extra_bits", FRAME_BITS + 5, 1'b0);

        build_random();
        run_frame("len56", 56, 1'b0);

`ifdef SPI_NOTE_RX_CHECKSUM_EN
        build_valid(1'b1, 8'h05, 7'h64, 32'h01234567);
        run_frame("ck_good", FRAME_BITS, 1'b0);
        fb[7] = ~fb[7];
        run_frame("ck_bad", FRAME_BITS, 1'b0);
`endif

        // Back-to-back frames with the minimum cs_n high gap.
        r0 = n_ready;
        e0 = n_err;
        voice_q.delete();
        build_valid(1'b1, 8'h00, 7'($urandom), $urandom);
        send_frame(FRAME_BITS, 4, 1'b0, -1);
        build_valid(1'b0, 8'hFF, 7'($urandom), $urandom);
        send_frame(FRAME_BITS, 12, 1'b0, -1);
        model_load();
        check_val("b2b_nready", 64'(n_ready - r0), 64'd2);
        check_val("b2b_nerr",   64'(n_err - e0),   64'd0);
        check_val("b2b_qsize",  64'(voice_q.size()), 64'd2);
        if (voice_q.size() == 2) begin
            check_val("b2b_voice0", 64'(voice_q[0]), 64'h00);
            check_val("b2b_voice1", 64'(voice_q[1]), 64'hFF);
        end
        check_fields("b2b");

        // Reset partway through a frame, then a clean frame.
        r0 = n_ready;
        e0 = n_err;
        build_random();
        send_frame(FRAME_BITS, 0, 1'b0, 30);
        check_val("rst_nready", 64'(n_ready - r0), 64'd0);
        check_val("rst_nerr",   64'(n_err - e0),   64'd0);
        check_fields("rst_after");
        build_random();
        run_frame("post_rst", FRAME_BITS, 1'b0);

        for (int k = 0; k < 24; k++) begin
            build_random();
            mode = int'($urandom_range(0, 3));
            nb   = FRAME_BITS;
            if (mode == 1) begin
                p = int'($urandom_range(0, 7));
                if (p < 7) fb[0][p] = ~fb[0][p];
                else       fb[2][7] = 1'b1;
                if ($urandom_range(0, 1) == 1) fix_ck();
            end else if (mode == 2) begin
                nb = int'($urandom_range(1, FRAME_BITS - 1));
            end else if (mode == 3) begin
                nb = FRAME_BITS + int'($urandom_range(1, 7));
            end
            run_frame("rand", nb, (mode == 0) && ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
